// File: rtl/gpu_buf_pkg.sv
// rtl/gpu_buf_pkg.sv - shared types and defaults for the work buffer access arbiter
package gpu_buf_pkg;

  typedef enum logic [1:0] {
    BUF_OP_NONE,
    BUF_OP_PUSH,
    BUF_OP_POP
  } buf_op_e;

  localparam int BUF_DEPTH  = 16;
  localparam int BUF_DATA_W = 32;

endpackage

// File: rtl/buffer_access_arbiter_if.sv
// rtl/buffer_access_arbiter_if.sv - producer/consumer/buffer signal bundle of the arbiter
interface buffer_access_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = gpu_buf_pkg::BUF_DATA_W,
  parameter int DEPTH   = gpu_buf_pkg::BUF_DEPTH
);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic                        flush;
  logic [NUM_REQ-1:0]          push_req;
  logic [NUM_REQ*DATA_W-1:0]   push_data;
  logic [NUM_REQ-1:0]          push_grant;
  logic                        pop_req;
  logic                        pop_valid;
  logic [DATA_W-1:0]           pop_data;
  logic [OCC_W-1:0]            occupancy;
  logic                        buf_push;
  logic                        buf_pop;
  logic                        buf_read;
  logic                        buf_rst;
  logic [DATA_W-1:0]           buf_data_in;
  logic [DATA_W-1:0]           buf_data_out;

  modport slave (
    input  flush, push_req, push_data, pop_req, buf_data_out,
    output push_grant, pop_valid, pop_data, occupancy,
           buf_push, buf_pop, buf_read, buf_rst, buf_data_in
  );

  modport master (
    output flush, push_req, push_data, pop_req, buf_data_out,
    input  push_grant, pop_valid, pop_data, occupancy,
           buf_push, buf_pop, buf_read, buf_rst, buf_data_in
  );
endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting at an external pointer
module rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic             any,
  output logic [PTR_W-1:0] idx
);

  logic [PTR_W-1:0] pos;

  // Scan ptr, ptr+1, ... with an explicit wrap so N need not be a power of two.
  always_comb begin
    gnt = '0;
    any = 1'b0;
    idx = '0;
    pos = ptr;
    for (int k = 0; k < N; k++) begin
      if (!any && req[pos]) begin
        any      = 1'b1;
        gnt[pos] = 1'b1;
        idx      = pos;
      end
      pos = (pos == PTR_W'(N - 1)) ? '0 : pos + 1'b1;
    end
  end

endmodule

// File: rtl/buffer_access_arbiter.sv
// rtl/buffer_access_arbiter.sv - sequences producer pushes and consumer pops onto one circular buffer
module buffer_access_arbiter
  import gpu_buf_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int DATA_W         = BUF_DATA_W,
  parameter int DEPTH          = BUF_DEPTH,
  parameter int MAX_POP_STREAK = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  buffer_access_arbiter_if.slave    bus
);

  localparam int OCC_W    = $clog2(DEPTH + 1);
  localparam int PTR_W    = $clog2(NUM_REQ);
  localparam int STREAK_W = $clog2(MAX_POP_STREAK + 1);

  logic [OCC_W-1:0]    occupancy_q;
  logic [PTR_W-1:0]    rr_ptr;
  logic [STREAK_W-1:0] pop_streak;
  logic                pop_valid_q;

  logic [NUM_REQ-1:0]  arb_gnt;
  logic                arb_any;
  logic [PTR_W-1:0]    arb_idx;
  logic                can_pop;
  logic                can_push;
  logic                streak_full;
  logic [DATA_W-1:0]   win_data;
  buf_op_e             op;

  rr_arbiter #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_rr (
    .req (bus.push_req),
    .ptr (rr_ptr),
    .gnt (arb_gnt),
    .any (arb_any),
    .idx (arb_idx)
  );

  assign can_pop     = bus.pop_req && (occupancy_q != '0);
  assign can_push    = arb_any && (occupancy_q != OCC_W'(DEPTH));
  assign streak_full = (pop_streak == STREAK_W'(MAX_POP_STREAK));

  always_comb begin
    op = BUF_OP_NONE;
    if (rst || bus.flush) begin
      op = BUF_OP_NONE;
    end else if (can_pop && !(can_push && streak_full)) begin
      op = BUF_OP_POP;
    end else if (can_push) begin
      op = BUF_OP_PUSH;
    end
  end

  always_comb begin
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_gnt[i]) begin
        win_data = bus.push_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign bus.push_grant  = (op == BUF_OP_PUSH) ? arb_gnt : '0;
  assign bus.buf_push    = (op == BUF_OP_PUSH);
  assign bus.buf_pop     = (op == BUF_OP_POP);
  assign bus.buf_data_in = (op == BUF_OP_PUSH) ? win_data : '0;
  assign bus.buf_read    = 1'b0;
  assign bus.buf_rst     = rst || bus.flush;
  assign bus.occupancy   = occupancy_q;
  assign bus.pop_data    = bus.buf_data_out;
  // A pop issued just before a flush lands while the buffer is being cleared; hide it.
  assign bus.pop_valid   = pop_valid_q && !bus.flush && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      occupancy_q <= '0;
      rr_ptr      <= '0;
      pop_streak  <= '0;
      pop_valid_q <= 1'b0;
    end else if (bus.flush) begin
      occupancy_q <= '0;
      pop_streak  <= '0;
      pop_valid_q <= 1'b0;
    end else begin
      pop_valid_q <= (op == BUF_OP_POP);
      case (op)
        BUF_OP_PUSH: begin
          rr_ptr      <= (arb_idx == PTR_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
          occupancy_q <= occupancy_q + 1'b1;
          pop_streak  <= '0;
        end
        BUF_OP_POP: begin
          occupancy_q <= occupancy_q - 1'b1;
          if (!can_push) begin
            pop_streak <= '0;
          end else if (!streak_full) begin
            pop_streak <= pop_streak + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/buffer_access_arbiter.md
Name: buffer_access_arbiter

Overview:
- Sequences one shared instruction/work circular buffer (DEPTH entries, DATA_W wide, single push/pop port, one operation per cycle) between NUM_REQ producer lanes and one consumer (warp dispatch).
- Grants producers round-robin and gives pops priority, with an anti-starvation cap.
- Keeps its own occupancy count, so the buffer's full/empty flag quirks never gate correctness.
- Drives the buffer's push_buffer/pop_buffer strobes and its reset for flushes.

Parameters:
- NUM_REQ, 4, number of producer lanes (>=2).
- DATA_W, 32, buffer entry width.
- DEPTH, 16, buffer capacity; must equal the buffer's size.
- MAX_POP_STREAK, 4, maximum consecutive pops while an eligible push waits.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- flush  in  1  synchronous: empty the buffer and drop in-flight results.
- push_req  in  NUM_REQ  per-lane push request, level; hold until granted.
- push_data  in  NUM_REQ*DATA_W  per-lane data; lane i at bits [i*DATA_W +: DATA_W].
- push_grant  out  NUM_REQ  one-hot; the lane's data is written this cycle.
- pop_req  in  1  consumer requests one entry per cycle, level.
- pop_valid  out  1  popped entry valid this cycle.
- pop_data  out  DATA_W  popped entry.
- occupancy  out  $clog2(DEPTH+1)  current entry count.
- buf_push  out  1  drives the buffer's push_buffer.
- buf_pop  out  1  drives the buffer's pop_buffer.
- buf_read  out  1  drives the buffer's read_buffer; tied 0.
- buf_rst  out  1  drives the buffer's rst.
- buf_data_in  out  DATA_W  drives the buffer's data_in.
- buf_data_out  in  DATA_W  the buffer's data_out.

Behaviour:
- **Clock and reset:** clk is the only clock. rst is synchronous and active-high.
- **State on reset:** occupancy=0, rr_ptr=0, pop_streak=0, pop_valid=0.
- **Outputs during rst:** buf_rst=1 combinationally; all strobes and grants are 0.
- **Registered vs combinational:** push_grant, buf_push, buf_pop and buf_data_in are combinational from inputs and registered state. pop_valid is registered. pop_data = buf_data_out passthrough.
- **Eligibility per cycle:**
  - can_pop = pop_req && occupancy>0.
  - can_push = |push_req && occupancy<DEPTH.
- **Decision, one operation per cycle, never both:**
  - If flush or rst: no operation.
  - Else if can_pop && !(can_push && pop_streak==MAX_POP_STREAK): pop.
  - Else if can_push: push.
  - Else: none.
- **Push:**
  - The winner is the first requesting lane at or after rst_ptr order: lane with request scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - Assert push_grant[w], buf_push=1, buf_data_in=push_data[w].
  - Next state: rr_ptr <= (w+1) mod NUM_REQ; occupancy +1; pop_streak <= 0.
- **Pop:**
  - Assert buf_pop=1; occupancy -1.
  - pop_streak +1 if can_push, else 0; saturate at MAX_POP_STREAK.
  - pop_valid=1 in the next cycle, with pop_data = buf_data_out; latency 1 from the pop cycle.
  - Back-to-back pops give back-to-back pop_valid.
- **Idle cycles:** buf_data_in = 0, and rr_ptr and pop_streak hold.
- **Full (occupancy==DEPTH):** no push grants; pops proceed.
- **Empty:** pop_req is ignored; pop_valid=0 next cycle; no strobe to the buffer.
- **Flush (sampled at clock edge):**
  - buf_rst=1 in the same cycle, combinational from flush.
  - occupancy<=0 and pop_streak<=0.
  - pop_valid<=0, including a pop issued the cycle before the flush, which is suppressed.
  - rr_ptr holds.
  - No grants during the flush cycle; pending push_req are served from the next cycle.
- **Reset mid-operation:** same as flush, plus rr_ptr<=0.
- **Wrap-around:** handled by the buffer. The controller counts only; occupancy never exceeds DEPTH or underflows (bench assertions).
- **Arithmetic:**
  - occupancy is an unsigned count, $clog2(DEPTH+1) bits.
  - rr_ptr is $clog2(NUM_REQ) bits, wrapping via explicit compare, not a power-of-2 assumption.
  - pop_streak is $clog2(MAX_POP_STREAK+1) bits.

Decomposition:
- Package gpu_buf_pkg:
  - enum buf_op_e {BUF_OP_NONE, BUF_OP_PUSH, BUF_OP_POP}, the per-cycle decision.
  - Default constants BUF_DEPTH and BUF_DATA_W, shared with the buffer instance.
- Sub-module rr_arbiter:
  - Parameter N.
  - Inputs: req[N], ptr.
  - Outputs: one-hot gnt[N], any, idx.
  - Purely combinational; the pointer is owned by the parent.
- Parent contains the decision logic, counters, pop_valid register and flush handling.

Test Plan:
- Settings: NUM_REQ=4, DEPTH=4, DATA_W=16, MAX_POP_STREAK=2. Each scenario runs against a real circular buffer instance.
- **Reset:** rst for 2 cycles with all push_req=1 -> no grants, buf_rst=1 each cycle, occupancy=0 and pop_valid=0 after release.
- **Round-robin:** push_req=4'b1111, data 0xA0..0xA3, hold until granted -> grants lane 0,1,2,3 on consecutive cycles. Then occupancy=4, all push_req stay pending, no grant. Then pop_req 4 cycles -> pop_valid each following cycle with 0xA0,0xA1,0xA2,0xA3.
- **Empty pop:** occupancy=0, pop_req=1 for 3 cycles -> buf_pop=0, pop_valid=0. Then lane 2 pushes 0x55 -> next cycle a pop issues and pop_valid shows 0x55 one cycle later.
- **Starvation cap:** occupancy=3, pop_req=1 held, lane 1 push_req=1 -> pop, pop, then push (grant[1]), then pop. Occupancy sequence 3,2,1,2,1.
- **Flush in flight:** pop issued in cycle N, flush in cycle N+1 -> pop_valid=0 in N+1, buf_rst=1, occupancy=0. A push in N+2 is stored and popped back intact.
- **Wrap:** 10 interleaved push/pop cycles with values 1..10 -> pop_data order 1..10, occupancy never >4 or <0.
